// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time instruction memory loader.
package loader_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_t;
endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; flags the byte that completes it.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic [LANE_W-1:0] lane,
  output logic              word_full
);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= '0;
      word <= '0;
    end else if (en) begin
      word[lane*BYTE_W +: BYTE_W] <= data;
      // lane wraps to 0 on its own after the 4th byte
      lane <= lane + 1'b1;
    end
  end

  assign word_full = en && (lane == LANE_W'(LANES - 1));
endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream and keeps the core in reset until the image is written.
// Byte handshake: a byte moves on a clk edge only when InValid and InReady are both high.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  NumWords,
  input  logic              InValid,
  input  logic [BYTE_W-1:0] InData,
  output logic              InReady,
  output logic              ImemWrite,
  output logic [31:0]       ImemAdr,
  output logic [WORD_W-1:0] ImemWriteData,
  output logic              CoreReset,
  output logic              Done,
  output logic              Error,
  output loader_state_t     fsm_state
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_t     state, next_state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  word_idx;
  logic [LANE_W-1:0] byte_idx;
  logic              start_ok, load, accept, word_full, last_word;

  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign load      = start_ok && (NumWords != '0) && (NumWords <= DEPTH_C);
  assign accept    = InValid && (state == ST_RECV);
  assign last_word = (word_idx + CNT_W'(1)) == count;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .en        (accept),
    .data      (InData),
    .word      (ImemWriteData),
    .lane      (byte_idx),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (NumWords == '0)         next_state = ST_DONE;
          else if (NumWords > DEPTH_C) next_state = ST_ERROR;
          else                         next_state = ST_RECV;
        end
      end
      ST_RECV:  if (word_full) next_state = ST_WRITE;
      ST_WRITE: next_state = last_word ? ST_DONE : ST_RECV;
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
      count    <= '0;
    end else if (load) begin
      word_idx <= '0;
      count    <= NumWords;
    end else if (state == ST_WRITE) begin
      word_idx <= word_idx + CNT_W'(1);
    end
  end

  always_comb begin
    InReady   = 1'b0;
    ImemWrite = 1'b0;
    CoreReset = 1'b1;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state)
      ST_RECV:  InReady   = 1'b1;
      ST_WRITE: ImemWrite = 1'b1;
      ST_DONE: begin
        CoreReset = 1'b0;
        Done      = 1'b1;
      end
      ST_ERROR: Error = 1'b1;
      default: ;
    endcase
  end

  assign ImemAdr   = 32'({word_idx, 2'b00});
  assign fsm_state = state;

  logic unused_lane;
  assign unused_lane = ^byte_idx;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: write scoreboard plus directed handshake and timing checks.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, start, InValid;
  logic [CNT_W-1:0] NumWords;
  logic [7:0]       InData;
  logic             InReady, ImemWrite, CoreReset, Done, Error;
  logic [31:0]      ImemAdr, ImemWriteData;
  loader_state_t    fsm_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int cyc = 0;
  int ready_total = 0;
  int e_cyc = 0;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .NumWords      (NumWords),
    .InValid       (InValid),
    .InData        (InData),
    .InReady       (InReady),
    .ImemWrite     (ImemWrite),
    .ImemAdr       (ImemAdr),
    .ImemWriteData (ImemWriteData),
    .CoreReset     (CoreReset),
    .Done          (Done),
    .Error         (Error),
    .fsm_state     (fsm_state)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    ready_total <= ready_total + int'(InReady);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write monitor: every ImemWrite cycle must match the head of the expected queue
  always @(negedge clk) begin
    if (ImemWrite) begin
      n_writes++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("imem_write", {ImemAdr, ImemWriteData}, exp_q.pop_front());
    end
  end

  // driver tasks; each is entered and left at a negedge
  task automatic do_reset();
    reset = 1'b1;
    InValid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    NumWords = CNT_W'(n);
    @(negedge clk);
    e_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    InValid = 1'b1;
    InData = b;
    while (!InReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready_timeout", 64'(InReady), 64'd1);
    @(negedge clk);
    InValid = 1'b0;
  endtask

  task automatic gap();
    InValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit seen, output int cyc_idx, output bit prev_core);
    seen = 1'b0;
    prev_core = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      prev_core = CoreReset;
      @(negedge clk);
    end
    cyc_idx = cyc - e_cyc + 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit   seen, prev_core;
    int   idx, w0, r0;
    logic [31:0] wd;

    reset = 1'b1; start = 1'b0; NumWords = '0; InValid = 1'b0; InData = '0;
    idle_cycles(2);
    do_reset();

    // reset state
    check("rst_core_reset", 64'(CoreReset), 64'd1);
    check("rst_in_ready",   64'(InReady),   64'd0);
    check("rst_imem_write", 64'(ImemWrite), 64'd0);
    check("rst_done",       64'(Done),      64'd0);
    check("rst_error",      64'(Error),     64'd0);
    check("rst_adr",        64'(ImemAdr),   64'd0);
    check("rst_wdata",      64'(ImemWriteData), 64'd0);

    // two words, InValid held high: Done in cycle 5N+1 after the start edge
    exp_q.push_back({32'd0, 32'h0001_0203});
    exp_q.push_back({32'd4, 32'hDEAD_BEEF});
    do_start(2);
    begin
      logic [7:0] bytes [8] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 8; i++) push_byte(bytes[i]);
    end
    wait_done(50, seen, idx, prev_core);
    check("t1_done_seen",  64'(seen), 64'd1);
    check("t1_done_cycle", 64'(idx), 64'd11);
    check("t1_core_prev",  64'(prev_core), 64'd1);
    check("t1_core_low",   64'(CoreReset), 64'd0);
    check("t1_q_empty",    64'(exp_q.size()), 64'd0);

    // one word from DONE, InValid toggling with a leading gap: 8 RECV cycles
    exp_q.push_back({32'd0, 32'h4433_2211});
    r0 = ready_total;
    do_start(1);
    check("t2_core_reasserted", 64'(CoreReset), 64'd1);
    begin
      logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
        gap();
        push_byte(bytes[i]);
      end
    end
    wait_done(50, seen, idx, prev_core);
    check("t2_done_seen",   64'(seen), 64'd1);
    check("t2_ready_cycles", 64'(ready_total - r0), 64'd8);
    check("t2_done_cycle",  64'(idx), 64'd10);

    // oversize request goes to ERROR and stays there until reset
    w0 = n_writes;
    do_start(DEPTH + 1);
    check("t3_error",      64'(Error), 64'd1);
    check("t3_core_reset", 64'(CoreReset), 64'd1);
    check("t3_done",       64'(Done), 64'd0);
    InValid = 1'b1; start = 1'b1; NumWords = CNT_W'(1);
    idle_cycles(5);
    InValid = 1'b0; start = 1'b0;
    check("t3_error_held", 64'(Error), 64'd1);
    check("t3_ready_low",  64'(InReady), 64'd0);
    check("t3_no_writes",  64'(n_writes - w0), 64'd0);
    do_reset();
    check("t3_error_clear", 64'(Error), 64'd0);
    check("t3_core_after",  64'(CoreReset), 64'd1);

    // zero words: Done on the next cycle, nothing written
    w0 = n_writes;
    do_start(0);
    check("t4_done",     64'(Done), 64'd1);
    check("t4_core_low", 64'(CoreReset), 64'd0);
    idle_cycles(4);
    check("t4_no_writes", 64'(n_writes - w0), 64'd0);

    // reset mid-word: the partial word 1 is never written
    exp_q.push_back({32'd0, 32'h0D0C_0B0A});
    do_start(3);
    begin
      logic [7:0] bytes [6] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h55, 8'h66};
      for (int i = 0; i < 6; i++) push_byte(bytes[i]);
    end
    do_reset();
    check("t5_core_reset", 64'(CoreReset), 64'd1);
    check("t5_adr_cleared", 64'(ImemAdr), 64'd0);
    exp_q.push_back({32'd0, 32'hA4A3_A2A1});
    do_start(1);
    begin
      logic [7:0] bytes [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int i = 0; i < 4; i++) push_byte(bytes[i]);
    end
    wait_done(50, seen, idx, prev_core);
    check("t5_done_seen", 64'(seen), 64'd1);
    check("t5_q_empty",   64'(exp_q.size()), 64'd0);

    // full-depth load with counting bytes; a start pulse mid-load is ignored
    w0 = n_writes;
    for (int k = 0; k < DEPTH; k++) begin
      wd = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      exp_q.push_back({32'(4*k), wd});
    end
    do_start(DEPTH);
    for (int i = 0; i < 4*DEPTH; i++) begin
      if (i == 41) begin
        start = 1'b1;
        NumWords = CNT_W'(1);
      end
      if (i == 44) start = 1'b0;
      push_byte(8'(i));
    end
    wait_done(100, seen, idx, prev_core);
    check("t6_done_seen",  64'(seen), 64'd1);
    check("t6_done_cycle", 64'(idx), 64'(5*DEPTH + 1));
    check("t6_writes",     64'(n_writes - w0), 64'(DEPTH));
    check("t6_q_empty",    64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
